// File: rtl/status_bank.sv
// Bank of DEPTH status registers with load/set/clear/toggle writes and a shadow
// stack for entry 0. Define STATUS_BANK_RDREG_EN for a registered (1-cycle) rdata.
module status_bank #(
  parameter  int WIDTH     = 8,
  parameter  int ADDR_W    = 4,
  parameter  int STK_DEPTH = 4,
  localparam int DEPTH     = 2 ** ADDR_W,
  localparam int CNT_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  stk_cnt,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] stk [STK_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;

  logic             push_ok;
  logic             pop_ok;
  logic             push_err;
  logic             pop_err;
  logic             wr_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [WIDTH-1:0] wr_val;

  assign stk_full  = (cnt_q == CNT_W'(STK_DEPTH));
  assign stk_empty = (cnt_q == '0);
  assign stk_cnt   = cnt_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

  // Simultaneous push and pop cancel each other completely, errors included.
  assign push_ok  = push & ~pop & ~stk_full;
  assign pop_ok   = pop & ~push & ~stk_empty;
  assign push_err = push & ~pop & stk_full;
  assign pop_err  = pop & ~push & stk_empty;
  assign push_idx = IDX_W'(cnt_q);
  assign pop_idx  = IDX_W'(cnt_q - 1'b1);

  // A restore into entry 0 takes priority over a same-cycle write to it.
  assign wr_en = we & ~(pop_ok & (waddr == '0));

  always_comb begin
    wr_val = mem[waddr];
    case (op)
      OP_LOAD:   wr_val = wdata;
      OP_SET:    wr_val = mem[waddr] | wdata;
      OP_CLEAR:  wr_val = mem[waddr] & ~wdata;
      OP_TOGGLE: wr_val = mem[waddr] ^ wdata;
      default:   wr_val = mem[waddr];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en) mem[waddr] <= wr_val;
      if (pop_ok) begin
        mem[0] <= stk[pop_idx];
        cnt_q  <= cnt_q - 1'b1;
      end
      // mem[0] here is the pre-edge value, so a same-cycle write is not captured.
      if (push_ok) begin
        stk[push_idx] <= mem[0];
        cnt_q         <= cnt_q + 1'b1;
      end
      if (push_err)     ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (pop_err)      unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

`ifdef STATUS_BANK_RDREG_EN
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
`else
  assign rdata = mem[raddr];
`endif

endmodule
